commit_trace_buffer: RTL and testbench

// Buffers architectural commit events (GRF writes, DM writes) from the CPU core (Main) and replays

---
 rtl/commit_trace_buffer.sv | 126 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: queues GRF/DM commit events from the core in a
// circular FIFO and replays them in program order over a valid/ready stream.
// Up to two events enter per cycle (GRF first, then DM); events that do not
// fit are dropped and recorded in a sticky overflow flag.
module commit_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          GRF_WE,
    input  logic [4:0]    GRF_Addr,
    input  logic [31:0]   GRF_WD,
    input  logic          DM_WE,
    input  logic [31:0]   DM_Addr,
    input  logic [31:0]   DM_WD,
    input  logic [31:0]   PC,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic          Out_Type,
    output logic [31:0]   Out_PC,
    output logic [31:0]   Out_Addr,
    output logic [31:0]   Out_Data,
    output logic [AW:0]   Count,
    output logic          Overflow
);

    // Entry layout: {type, pc, addr, data}
    localparam int EW = 97;

    logic [EW-1:0] storage [DEPTH];

    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;

    logic          grf_ev;
    logic          dm_ev;
    logic          pop;
    logic [1:0]    push_num;
    logic [AW+1:0] free_slots;
    logic [1:0]    acc_num;
    logic          drop;
    logic [EW-1:0] grf_entry;
    logic [EW-1:0] dm_entry;
    logic [EW-1:0] entry0;
    logic [EW-1:0] entry1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW:0]   count_next;
    logic [EW-1:0] head;

    // Event filtering, space check and acceptance decision (uses pre-edge count)
    always_comb begin
        grf_ev     = GRF_WE && (GRF_Addr != 5'd0);
        dm_ev      = DM_WE;
        pop        = (count_reg != '0) && Out_Ready;
        push_num   = {1'b0, grf_ev} + {1'b0, dm_ev};
        free_slots = (AW+2)'(DEPTH) - (AW+2)'(count_reg) + (AW+2)'(pop);
        acc_num    = 2'd0;
        drop       = 1'b0;
        if ((AW+2)'(push_num) <= free_slots) begin
            acc_num = push_num;
        end else if (push_num == 2'd2 && free_slots == (AW+2)'(1)) begin
            // Only room for one: the GRF entry is older in program order
            acc_num = 2'd1;
            drop    = 1'b1;
        end else begin
            acc_num = 2'd0;
            drop    = (push_num != 2'd0);
        end

        grf_entry  = {1'b0, PC, {27'b0, GRF_Addr}, GRF_WD};
        dm_entry   = {1'b1, PC, DM_Addr, DM_WD};
        entry0     = grf_ev ? grf_entry : dm_entry;
        entry1     = dm_entry;
        we0        = (acc_num != 2'd0);
        we1        = (acc_num == 2'd2);
        wr_ptr_inc = wr_ptr_reg + AW'(1);
        count_next = count_reg + (AW+1)'(acc_num) - (AW+1)'(pop);
    end

    // Entry storage: no reset on contents, up to two writes at consecutive slots
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (we0) begin
                storage[wr_ptr_reg] <= entry0;
            end
            if (we1) begin
                storage[wr_ptr_inc] <= entry1;
            end
        end
    end

    // Pointer, occupancy and sticky overflow state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(acc_num);
            rd_ptr_reg <= rd_ptr_reg + AW'(pop);
            count_reg  <= count_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head presentation: fields forced to zero while empty for clean waveforms
    always_comb begin
        head      = storage[rd_ptr_reg];
        Out_Valid = (count_reg != '0);
        Out_Type  = Out_Valid ? head[96] : 1'b0;
        Out_PC    = Out_Valid ? head[95:64] : 32'd0;
        Out_Addr  = Out_Valid ? head[63:32] : 32'd0;
        Out_Data  = Out_Valid ? head[31:0] : 32'd0;
        Count     = count_reg;
        Overflow  = overflow_reg;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Testbench for commit_trace_buffer: a hand-computed vector table for the
// single-cycle cases, then modelled sequences for fill, overflow, wrap and reset.
module tb_commit_trace_buffer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        GRF_WE;
    logic [4:0]  GRF_Addr;
    logic [31:0] GRF_WD;
    logic        DM_WE;
    logic [31:0] DM_Addr;
    logic [31:0] DM_WD;
    logic [31:0] PC;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Out_Type;
    logic [31:0] Out_PC;
    logic [31:0] Out_Addr;
    logic [31:0] Out_Data;
    logic [4:0]  Count;
    logic        Overflow;

    int tests_run = 0;
    int tests_failed = 0;

    commit_trace_buffer #(.DEPTH(16), .AW(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .GRF_WE(GRF_WE), .GRF_Addr(GRF_Addr), .GRF_WD(GRF_WD),
        .DM_WE(DM_WE), .DM_Addr(DM_Addr), .DM_WD(DM_WD), .PC(PC),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Type(Out_Type),
        .Out_PC(Out_PC), .Out_Addr(Out_Addr), .Out_Data(Out_Data),
        .Count(Count), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst;
        logic        gwe;
        logic [4:0]  ga;
        logic [31:0] gwd;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] pc;
        logic        rdy;
        logic        e_valid;
        logic        e_type;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [4:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [10];

    // Scoreboard model of the FIFO
    logic [96:0] model_q [$];
    logic        model_ovf;

    task automatic drive(input logic rst, input logic gwe, input logic [4:0] ga,
                         input logic [31:0] gwd, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [31:0] pc, input logic rdy);
        Reset = rst; GRF_WE = gwe; GRF_Addr = ga; GRF_WD = gwd;
        DM_WE = dwe; DM_Addr = da; DM_WD = dwd; PC = pc; Out_Ready = rdy;
    endtask

    // One clocked transaction checked against the scoreboard model
    task automatic step(input string name, input logic rst, input logic gwe, input logic [4:0] ga,
                        input logic [31:0] gwd, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [31:0] pc, input logic rdy);
        int pre;
        int free_n;
        int p;
        bit d;
        bit gev;
        logic [96:0] exp_head;
        logic [96:0] act_head;
        bit ok;
        pre = model_q.size();
        d = (pre != 0) && rdy;
        gev = gwe && (ga != 5'd0);
        p = int'(gev) + int'(dwe);
        free_n = 16 - pre + int'(d);
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (d) void'(model_q.pop_front());
            if (p <= free_n) begin
                if (gev) model_q.push_back({1'b0, pc, {27'b0, ga}, gwd});
                if (dwe) model_q.push_back({1'b1, pc, da, dwd});
            end else if (p == 2 && free_n == 1) begin
                model_q.push_back({1'b0, pc, {27'b0, ga}, gwd});
                model_ovf = 1'b1;
            end else begin
                model_ovf = 1'b1;
            end
        end
        drive(rst, gwe, ga, gwd, dwe, da, dwd, pc, rdy);
        @(posedge Clk);
        #1;
        exp_head = (model_q.size() != 0) ? model_q[0] : 97'd0;
        act_head = {Out_Type, Out_PC, Out_Addr, Out_Data};
        ok = (int'(Count) == model_q.size()) && (Out_Valid == (model_q.size() != 0)) &&
             (Overflow == model_ovf) && ((model_q.size() == 0) || (act_head == exp_head));
        tests_run++;
        $display("[TB] %s: cnt=%0d v=%0d ovf=%0d head=%h", name, Count, Out_Valid, Overflow, act_head);
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s: got cnt=%0d v=%0d ovf=%0d head=%h, want cnt=%0d v=%0d ovf=%0d head=%h",
                     name, Count, Out_Valid, Overflow, act_head,
                     model_q.size(), (model_q.size() != 0), model_ovf, exp_head);
        end
    endtask

    initial begin
        logic [96:0] exp_v;
        logic [96:0] act_v;
        bit ok;

        // rst gwe ga gwd dwe da dwd pc rdy | valid type pc addr data count ovf
        vecs[0] = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,  32'h0,  32'h0,    1'b0,
                    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,  5'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'd5, 32'h12,   1'b0, 32'h0,  32'h0,  32'h3000, 1'b1,
                    1'b1, 1'b0, 32'h3000, 32'h5,  32'h12, 5'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,  32'h0,  32'h0,    1'b1,
                    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,  5'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 32'h0,  32'h0,  32'h3004, 1'b1,
                    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,  5'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd8, 32'h1,    1'b1, 32'h10, 32'h2,  32'h3004, 1'b0,
                    1'b1, 1'b0, 32'h3004, 32'h8,  32'h1,  5'd2, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,  32'h0,  32'h0,    1'b1,
                    1'b1, 1'b1, 32'h3004, 32'h10, 32'h2,  5'd1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,  32'h0,  32'h0,    1'b1,
                    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,  5'd0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 32'h20, 32'hAB, 32'h3008, 1'b0,
                    1'b1, 1'b1, 32'h3008, 32'h20, 32'hAB, 5'd1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 5'd3, 32'h7,    1'b0, 32'h0,  32'h0,  32'h300C, 1'b1,
                    1'b1, 1'b0, 32'h300C, 32'h3,  32'h7,  5'd1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,  32'h0,  32'h0,    1'b1,
                    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,  5'd0, 1'b0};

        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge Clk);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].gwe, vecs[i].ga, vecs[i].gwd, vecs[i].dwe,
                  vecs[i].da, vecs[i].dwd, vecs[i].pc, vecs[i].rdy);
            @(posedge Clk);
            #1;
            exp_v = {vecs[i].e_type, vecs[i].e_pc, vecs[i].e_addr, vecs[i].e_data};
            act_v = {Out_Type, Out_PC, Out_Addr, Out_Data};
            ok = (Out_Valid == vecs[i].e_valid) && (Count == vecs[i].e_count) &&
                 (Overflow == vecs[i].e_ovf) && (!vecs[i].e_valid || act_v == exp_v);
            tests_run++;
            $display("[TB] vec%0d: cnt=%0d v=%0d ovf=%0d head=%h", i, Count, Out_Valid, Overflow, act_v);
            if (!ok) begin
                tests_failed++;
                $display("FAIL vec%0d: got v=%0d cnt=%0d ovf=%0d head=%h, want v=%0d cnt=%0d ovf=%0d head=%h",
                         i, Out_Valid, Count, Overflow, act_v,
                         vecs[i].e_valid, vecs[i].e_count, vecs[i].e_ovf, exp_v);
            end
        end

        // Fill to DEPTH with the consumer stalled, then one more push overflows
        model_q.delete();
        model_ovf = 1'b0;
        step("reset_a", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 16; i++)
            step("fill", 1'b0, 1'b1, 5'((i % 31) + 1), 32'h100 + i, 1'b0, 32'd0, 32'd0,
                 32'h4000 + 4 * i, 1'b0);
        step("overflow17", 1'b0, 1'b1, 5'd9, 32'hDEAD, 1'b0, 32'd0, 32'd0, 32'h4100, 1'b0);
        // Full with pop and push in the same cycle
        step("full_pushpop", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h80, 32'h55, 32'h4104, 1'b1);
        // Interleaved push/pop across pointer wrap, alternating GRF and DM
        for (int i = 0; i < 30; i++)
            step("wrap", 1'b0, (i % 2 == 0), 5'((i % 30) + 1), 32'h200 + i, (i % 2 == 1),
                 32'h1000 + 4 * i, 32'h300 + i, 32'h5000 + 4 * i, 1'b1);
        for (int i = 0; i < 17; i++)
            step("drain", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        // Two events with exactly one free slot: GRF kept, DM dropped
        step("reset_b", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 15; i++)
            step("fill15", 1'b0, 1'b1, 5'd4, 32'h600 + i, 1'b0, 32'd0, 32'd0, 32'h6000 + 4 * i, 1'b0);
        step("two_one_free", 1'b0, 1'b1, 5'd6, 32'h777, 1'b1, 32'h44, 32'h888, 32'h6100, 1'b0);
        for (int i = 0; i < 9; i++)
            step("partial_drain", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        // Mid-stream reset at Count=7 with a push and pop pending
        step("mid_reset", 1'b1, 1'b1, 5'd2, 32'h9, 1'b1, 32'h8, 32'h9, 32'h7000, 1'b1);
        step("after_reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
